// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - edge-qualified hit/miss scoring with ms lockout and saturating counts.
// Define SCORE_SYNC_EN to put a 2-flop synchronizer on hit and miss ahead of edge detect.
module score_keeper #(
   parameter int WIN_SCORE  = 9,
   parameter int LOSE_COUNT = 9,
   parameter int LOCKOUT_MS = 50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clk_1ms,
   input  logic       new_game,
   input  logic       hit,
   input  logic       miss,
   output logic [4:0] player_score,
   output logic [4:0] gameOver,
   output logic       lockout,
   output logic       done
);

   localparam int LW = (LOCKOUT_MS > 0) ? $clog2(LOCKOUT_MS + 1) : 1;
   localparam logic [4:0]    WIN_L  = 5'(WIN_SCORE);
   localparam logic [4:0]    LOSE_L = 5'(LOSE_COUNT);
   localparam logic [LW-1:0] LOCK_L = LW'(LOCKOUT_MS);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_LOCKOUT, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [4:0]    score_q, score_d;
   logic [4:0]    miss_cnt_q, miss_cnt_d;
   logic [LW-1:0] lock_cnt_q, lock_cnt_d;
   logic          hit_dly_q, hit_dly_d;
   logic          miss_dly_q, miss_dly_d;
   logic          hit_in, miss_in;
   logic          hit_ev, miss_ev;

`ifdef SCORE_SYNC_EN
   logic hit_s1_q, hit_s1_d, hit_s2_q, hit_s2_d;
   logic miss_s1_q, miss_s1_d, miss_s2_q, miss_s2_d;

   always_comb begin
      hit_s1_d  = hit;
      hit_s2_d  = hit_s1_q;
      miss_s1_d = miss;
      miss_s2_d = miss_s1_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_s1_q  <= 1'b0;
         hit_s2_q  <= 1'b0;
         miss_s1_q <= 1'b0;
         miss_s2_q <= 1'b0;
      end else begin
         hit_s1_q  <= hit_s1_d;
         hit_s2_q  <= hit_s2_d;
         miss_s1_q <= miss_s1_d;
         miss_s2_q <= miss_s2_d;
      end
   end

   assign hit_in  = hit_s2_q;
   assign miss_in = miss_s2_q;
`else
   assign hit_in  = hit;
   assign miss_in = miss;
`endif

   assign hit_ev  = hit_in & ~hit_dly_q;
   assign miss_ev = miss_in & ~miss_dly_q;

   always_comb begin
      state_d    = state_q;
      score_d    = score_q;
      miss_cnt_d = miss_cnt_q;
      lock_cnt_d = lock_cnt_q;
      hit_dly_d  = hit_in;
      miss_dly_d = miss_in;

      if (new_game) begin
         // A restart wins over any event arriving in the same cycle.
         score_d    = '0;
         miss_cnt_d = '0;
         lock_cnt_d = '0;
         state_d    = S_ARMED;
      end else begin
         case (state_q)
            S_ARMED: begin
               if (hit_ev || miss_ev) begin
                  if (hit_ev) begin
                     if (score_q < WIN_L) score_d = score_q + 5'd1;
                  end else if (miss_cnt_q < LOSE_L) begin
                     miss_cnt_d = miss_cnt_q + 5'd1;
                  end
                  if (score_d == WIN_L || miss_cnt_d == LOSE_L) begin
                     state_d = S_DONE;
                  end else if (LOCKOUT_MS > 0) begin
                     state_d    = S_LOCKOUT;
                     lock_cnt_d = '0;
                  end
               end
            end
            S_LOCKOUT: begin
               if (clk_1ms) begin
                  lock_cnt_d = lock_cnt_q + 1'b1;
                  if (lock_cnt_d == LOCK_L) state_d = S_ARMED;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         score_q    <= '0;
         miss_cnt_q <= '0;
         lock_cnt_q <= '0;
         hit_dly_q  <= 1'b0;
         miss_dly_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         score_q    <= score_d;
         miss_cnt_q <= miss_cnt_d;
         lock_cnt_q <= lock_cnt_d;
         hit_dly_q  <= hit_dly_d;
         miss_dly_q <= miss_dly_d;
      end
   end

   assign player_score = score_q;
   assign gameOver     = miss_cnt_q;
   assign lockout      = (state_q == S_LOCKOUT);
   assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed and random checks of score_keeper against a behavioural model.
module tb_score_keeper;

   localparam int WIN  = 9;
   localparam int LOSE = 9;
   localparam int LOCK = 50;
`ifdef SCORE_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       reset, clk_1ms, new_game, hit, miss;
   logic [4:0] player_score, gameOver;
   logic       lockout, done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit rand_strobe = 1'b0;

   // Model: mode 0 idle, 1 armed, 2 locked out, 3 done; m_left counts strobes still owed.
   int m_score, m_miss, m_mode, m_left;
   bit hh[4];
   bit mh[4];

   score_keeper #(.WIN_SCORE(WIN), .LOSE_COUNT(LOSE), .LOCKOUT_MS(LOCK)) dut (
      .clk(clk), .reset(reset), .clk_1ms(clk_1ms), .new_game(new_game),
      .hit(hit), .miss(miss), .player_score(player_score), .gameOver(gameOver),
      .lockout(lockout), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_score = 0;
      m_miss  = 0;
      m_mode  = 0;
      m_left  = 0;
      for (int i = 0; i < 4; i++) begin
         hh[i] = 1'b0;
         mh[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      bit eh, em;
      for (int i = 3; i > 0; i--) begin
         hh[i] = hh[i-1];
         mh[i] = mh[i-1];
      end
      hh[0] = hit;
      mh[0] = miss;
      eh = hh[LAT-1] & ~hh[LAT];
      em = mh[LAT-1] & ~mh[LAT];
      if (new_game) begin
         m_score = 0;
         m_miss  = 0;
         m_mode  = 1;
      end else if (m_mode == 1) begin
         if (eh) m_score++;
         else if (em) m_miss++;
         if (eh || em) begin
            if (m_score == WIN || m_miss == LOSE) m_mode = 3;
            else begin
               m_mode = 2;
               m_left = LOCK;
            end
         end
      end else if (m_mode == 2 && clk_1ms) begin
         m_left--;
         if (m_left == 0) m_mode = 1;
      end
   endtask

   task automatic step();
      clk_1ms = rand_strobe ? 1'($urandom_range(0, 1)) : (cyc % 10 == 9);
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check("score", player_score, m_score);
      check("misses", gameOver, m_miss);
      check("lockout", lockout, (m_mode == 2));
      check("done", done, (m_mode == 3));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic ng_pulse();
      new_game = 1'b1;
      step();
      new_game = 1'b0;
   endtask

   task automatic pulse(input bit h, input bit m, input int gap_ms);
      hit  = h;
      miss = m;
      run(2);
      hit  = 1'b0;
      miss = 1'b0;
      run(gap_ms * 10);
   endtask

   initial begin
      hit = 1'b0; miss = 1'b0; new_game = 1'b0; clk_1ms = 1'b0;
      reset = 1'b1;
      model_reset();
      #12;
      check("rst_score", player_score, 0);
      check("rst_misses", gameOver, 0);
      check("rst_lockout", lockout, 0);
      check("rst_done", done, 0);
      #1 reset = 1'b0;

      pulse(1, 0, 1);
      check("idle_ignored", player_score, 0);

      ng_pulse();
      for (int i = 0; i < 3; i++) pulse(1, 0, 60);
      check("t1_score", player_score, 3);
      check("t1_misses", gameOver, 0);
      check("t1_done", done, 0);

      ng_pulse();
      hit = 1'b1; step(); hit = 1'b0; run(100);
      hit = 1'b1; step(); hit = 1'b0; run(450);
      hit = 1'b1; step(); hit = 1'b0; run(20);
      check("t2_score", player_score, 2);

      ng_pulse();
      for (int i = 0; i < 10; i++) pulse(1, 0, 55);
      check("t3_score", player_score, 9);
      check("t3_done", done, 1);
      ng_pulse();
      check("t3_ng_score", player_score, 0);
      check("t3_ng_done", done, 0);

      ng_pulse();
      hit = 1'b1; miss = 1'b1; step();
      hit = 1'b0; miss = 1'b0; run(LAT + 1);
      check("t4_score", player_score, 1);
      check("t4_misses", gameOver, 0);
      run(550);
      for (int i = 0; i < 9; i++) pulse(0, 1, 55);
      check("t4_misses9", gameOver, 9);
      check("t4_done", done, 1);

      ng_pulse();
      for (int i = 0; i < 3; i++) pulse(1, 0, 55);
      pulse(1, 0, 1);
      check("t5_pre_score", player_score, 4);
      check("t5_pre_lockout", lockout, 1);
      #3 reset = 1'b1;
      #1;
      model_reset();
      check("t5_rst_score", player_score, 0);
      check("t5_rst_lockout", lockout, 0);
      check("t5_rst_done", done, 0);
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) pulse(1, 0, 2);
      check("t5_idle_score", player_score, 0);

      ng_pulse();
      hit = 1'b1;
      for (int i = 1; i <= LAT; i++) begin
         step();
         check("t6_latency", player_score, (i == LAT) ? 1 : 0);
      end
      hit = 1'b0;
      run(5);

      rand_strobe = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 3) == 0) hit = ~hit;
         if ($urandom_range(0, 4) == 0) miss = ~miss;
         new_game = ($urandom_range(0, 299) == 0);
         step();
      end
      new_game = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/score_keeper.md
# score_keeper

Upstream scoring stage for the game controller. Turns raw hit and miss inputs into edge-qualified events, with a millisecond lockout against double counts. Keeps the saturating `player_score` and `gameOver` (miss) counts that feed the win/lose state block, and freezes once either count reaches its limit.

## Interface
Parameters:
- `WIN_SCORE`, default 9: score value at which counting stops (win).
- `LOSE_COUNT`, default 9: miss value at which counting stops (game over).
- `LOCKOUT_MS`, default 50: number of `clk_1ms` strobes ignored after an accepted event; 0 disables the lockout.

Ports (reset is asynchronous and active-high; one clock):
- `clk`, input, 1: system clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `clk_1ms`, input, 1: one-`clk`-cycle strobe, synchronous to `clk`, once per millisecond.
- `new_game`, input, 1: synchronous pulse; clears the counts and arms the block.
- `hit`, input, 1: raw hit level; its rising edge is a point.
- `miss`, input, 1: raw miss level; its rising edge is a miss.
- `player_score`, output, 5: current score, 0..`WIN_SCORE`.
- `gameOver`, output, 5: current miss count, 0..`LOSE_COUNT`.
- `lockout`, output, 1: high while in LOCKOUT.
- `done`, output, 1: high while in DONE.

## Operation
- Reset values: state IDLE; `player_score`=0, `gameOver`=0, `lockout`=0, `done`=0; edge-detect and sync flops = 0; lockout counter = 0.
- Edge detect: each input (after the optional synchronizer) is registered once. An event is `x & ~x_q`. Levels held high count once.
- States:
  - IDLE: events ignored. `new_game` -> ARMED.
  - ARMED: accepted event -> increment the matching counter. Then:
    - if the new score = `WIN_SCORE` or the new misses = `LOSE_COUNT` -> DONE;
    - else if `LOCKOUT_MS`>0 -> LOCKOUT with counter loaded to 0;
    - else stay in ARMED.
  - LOCKOUT: each `clk_1ms` strobe increments the counter. On the strobe that makes it equal `LOCKOUT_MS` -> ARMED. Events in LOCKOUT are discarded, not queued.
  - DONE: counts held; events ignored. `new_game` -> ARMED.
- `new_game` in any state, on the next edge:
  - clears both counts and the lockout counter;
  - goes to ARMED;
  - an event in that same cycle is discarded.
- Simultaneous hit and miss events in ARMED: hit is counted, miss is dropped, one transition only.
- Counters never exceed their limits; no wrap-around. Counter width is 5 bits, so both limits must be ≤31.
- The lockout counter is `$clog2(LOCKOUT_MS+1)` bits wide, minimum 1.

## Timing
- Input-to-count latency without the synchronizer: the first clock edge sampling `hit`=1 after `hit`=0 updates `player_score`, visible after that edge (1 cycle).
- With `SCORE_SYNC_EN`: two extra flops, so the count is visible after the 3rd edge.
- `done` and `lockout` are asserted in the same cycle as the count update that causes them.
- `lockout` duration: from event acceptance to the `LOCKOUT_MS`-th subsequent `clk_1ms` strobe. The strobe coincident with the accepting edge is not counted.
- Asynchronous `reset` mid-LOCKOUT or in DONE immediately forces all reset values. After deassertion the block waits in IDLE for `new_game`.

## Configuration
- `SCORE_SYNC_EN`
  - Defined: `hit` and `miss` each pass through a 2-flop synchronizer (reset to 0) before edge detect, so asynchronous button inputs are safe.
  - Undefined: inputs feed edge detect directly and must be synchronous to `clk`; latency is 1 cycle.
  - All other behaviour is identical.

## Test plan
- Reset then `new_game`; pulse `hit` 3 times spaced over 60 ms (`LOCKOUT_MS`=50) -> `player_score`=3, `gameOver`=0, `done`=0.
- Hit edge, second hit edge 10 ms later, third hit edge at 55 ms -> second discarded; `player_score`=2. `lockout`=1 exactly until the 50th strobe.
- 9 spaced hits -> `player_score`=9, `done`=1 on the 9th. A 10th hit leaves the score at 9. `new_game` -> both counts 0, `done`=0.
- `hit` and `miss` rising in the same cycle while ARMED -> `player_score`+1, `gameOver` unchanged. 9 spaced misses -> `gameOver`=9, `done`=1.
- Assert `reset` during LOCKOUT with `player_score`=4 -> all outputs 0 asynchronously. Hit edges before `new_game` are ignored (score stays 0).
- With and without `SCORE_SYNC_EN`, a hit edge appears on `player_score` after 3 and after 1 clock edges respectively.
